// File: rtl/i2c_slave_write_sequencer.sv
// I2C slave write-path sequencer.
// Synchronises the SCL/SDA pads, detects START/STOP, and steps through address and data
// phases. It acknowledges its own address for writes, strobes each accepted data byte into
// the Data In buffer, and NACKs reads, foreign addresses and bytes beyond NUM_BYTES.
module i2c_slave_write_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_BYTES  = 6,
  localparam int        IDX_W      = $clog2(NUM_BYTES),
  localparam int        CNT_W      = IDX_W + 1
) (
  input  logic             FPGA_clk,
  input  logic             rst,
  input  logic             SCL_i,
  input  logic             SDA_i,
  output logic             sda_pull_o,
  output logic [7:0]       rx_byte_o,
  output logic             rx_valid_o,
  output logic [IDX_W-1:0] rx_index_o,
  output logic [CNT_W-1:0] byte_count_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t           state_q;
  logic             sclSync1_q, sclSync2_q, sclHist_q;
  logic             sdaSync1_q, sdaSync2_q, sdaHist_q;
  logic [6:0]       shift_q;
  logic [7:0]       shift_d;
  logic [2:0]       bitCnt_q;
  logic             ackPhase_q;
  logic             sdaPull_q;
  logic [7:0]       rxByte_q;
  logic             rxValid_q;
  logic [IDX_W-1:0] rxIndex_q;
  logic [CNT_W-1:0] byteCount_q;
  logic             busy_q;
  logic             overflow_q;
  logic             done_q;

  logic sclRise, sclFall, startDet, stopDet;

  // Bus events seen through the synchroniser, and the byte as it would look after this bit
  assign sclRise  =  sclSync2_q & ~sclHist_q;
  assign sclFall  = ~sclSync2_q &  sclHist_q;
  assign startDet =  sclSync2_q & ~sdaSync2_q &  sdaHist_q;
  assign stopDet  =  sclSync2_q &  sdaSync2_q & ~sdaHist_q;
  assign shift_d  = {shift_q, sdaSync2_q};

  // Two-flop synchronisers plus one history flop per pad; reset to the idle-bus level
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      sclSync1_q <= 1'b1;
      sclSync2_q <= 1'b1;
      sclHist_q  <= 1'b1;
      sdaSync1_q <= 1'b1;
      sdaSync2_q <= 1'b1;
      sdaHist_q  <= 1'b1;
    end else begin
      sclSync1_q <= SCL_i;
      sclSync2_q <= sclSync1_q;
      sclHist_q  <= sclSync2_q;
      sdaSync1_q <= SDA_i;
      sdaSync2_q <= sdaSync1_q;
      sdaHist_q  <= sdaSync2_q;
    end
  end

  // Transaction FSM; START/STOP take priority over any bit or ACK activity in the same cycle
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      ackPhase_q  <= 1'b0;
      sdaPull_q   <= 1'b0;
      rxByte_q    <= '0;
      rxValid_q   <= 1'b0;
      rxIndex_q   <= '0;
      byteCount_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      done_q    <= 1'b0;
      if (startDet) begin
        state_q     <= ADDR;
        bitCnt_q    <= '0;
        ackPhase_q  <= 1'b0;
        sdaPull_q   <= 1'b0;
        byteCount_q <= '0;
        overflow_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else if (stopDet) begin
        state_q    <= IDLE;
        ackPhase_q <= 1'b0;
        sdaPull_q  <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= busy_q && (byteCount_q != '0);
      end else begin
        case (state_q)
          IDLE: begin
          end
          ADDR: begin
            if (sclRise) begin
              shift_q  <= shift_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) begin
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaPull_q  <= 1'b1;
                busy_q     <= 1'b1;
                ackPhase_q <= 1'b1;
              end else begin
                sdaPull_q  <= 1'b0;
                ackPhase_q <= 1'b0;
                bitCnt_q   <= '0;
                state_q    <= DATA;
              end
            end
          end
          DATA: begin
            if (sclRise) begin
              shift_q  <= shift_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (byteCount_q < MAX_BYTES) begin
                  rxByte_q    <= shift_d;
                  rxIndex_q   <= byteCount_q[IDX_W-1:0];
                  rxValid_q   <= 1'b1;
                  byteCount_q <= byteCount_q + CNT_W'(1);
                  state_q     <= DATA_ACK;
                end else begin
                  overflow_q <= 1'b1;
                  state_q    <= IGNORE;
                end
              end
            end
          end
          IGNORE: begin
            sdaPull_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign sda_pull_o   = sdaPull_q;
  assign rx_byte_o    = rxByte_q;
  assign rx_valid_o   = rxValid_q;
  assign rx_index_o   = rxIndex_q;
  assign byte_count_o = byteCount_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_i2c_slave_write_sequencer.sv
// Testbench for i2c_slave_write_sequencer.
// Drives an open-drain I2C bus as a master would and keeps a transaction-level model of
// which bytes must be acknowledged and strobed out, plus when done must pulse.
module tb_i2c_slave_write_sequencer;

  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int         NUM_BYTES  = 6;

  logic       FPGA_clk = 1'b0;
  logic       rst;
  logic       sclPin;
  logic       sdaMaster;
  logic       sdaLine;
  logic       sdaPull;
  logic [7:0] rxByte;
  logic       rxValid;
  logic [2:0] rxIndex;
  logic [3:0] byteCount;
  logic       busy;
  logic       overflow;
  logic       done;

  // Open-drain bus: the line is low if either the master or the slave pulls it
  assign sdaLine = sdaMaster & ~sdaPull;

  i2c_slave_write_sequencer #(
    .SLAVE_ADDR(SLAVE_ADDR),
    .NUM_BYTES (NUM_BYTES)
  ) dut (
    .FPGA_clk    (FPGA_clk),
    .rst         (rst),
    .SCL_i       (sclPin),
    .SDA_i       (sdaLine),
    .sda_pull_o  (sdaPull),
    .rx_byte_o   (rxByte),
    .rx_valid_o  (rxValid),
    .rx_index_o  (rxIndex),
    .byte_count_o(byteCount),
    .busy_o      (busy),
    .overflow_o  (overflow),
    .done_o      (done)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } rxExp_t;

  rxExp_t     expRx[$];
  int         testsRun    = 0;
  int         testsFailed = 0;
  bit         modelMatched;
  int         modelCount;
  bit         modelOverflow;
  int         expDone     = 0;
  int         doneSeen    = 0;
  logic [7:0] lastRxByte  = '0;
  int         lastRxIdx   = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Checks every strobe against the model's queue and every done pulse against its count
  always @(negedge FPGA_clk) begin
    if (!rst) begin
      if (rxValid) begin
        if (expRx.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL rxUnexpected: got byte 0x%02h idx %0d, expected no strobe",
                   rxByte, rxIndex);
        end else begin
          rxExp_t e;
          e = expRx.pop_front();
          checkOutput("rxByte", 32'(rxByte), 32'(e.data));
          checkOutput("rxIndex", 32'(rxIndex), 32'(e.idx));
        end
        lastRxByte = rxByte;
        lastRxIdx  = int'(rxIndex);
      end
      if (done) begin
        doneSeen++;
        checkOutput("doneByteCount", 32'(byteCount), 32'(modelCount));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  task automatic applyStimulus(input logic scl, input logic sda, input int n);
    sclPin    = scl;
    sdaMaster = sda;
    waitCycles(n);
  endtask

  task automatic sendStart();
    applyStimulus(sclPin, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 6);
  endtask

  task automatic sendStop();
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b1, 10);
    if (modelMatched && modelCount >= 1) expDone++;
    modelMatched = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, b, 4);
    applyStimulus(1'b1, b, 8);
    applyStimulus(1'b0, b, 4);
  endtask

  task automatic sendBits(input logic [7:0] value, input int nBits);
    for (int i = 7; i > 7 - nBits; i--) sendBit(value[i]);
  endtask

  // Master releases SDA for the ninth clock and reports whether the slave held it low
  task automatic ackSlot(output logic acked);
    applyStimulus(1'b0, 1'b1, 4);
    sclPin = 1'b1;
    waitCycles(4);
    acked = (sdaLine == 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1, 4);
  endtask

  task automatic sendAddr(input logic [7:0] addrByte);
    logic acked;
    modelMatched  = (addrByte[7:1] == SLAVE_ADDR) && !addrByte[0];
    modelCount    = 0;
    modelOverflow = 1'b0;
    sendBits(addrByte, 8);
    ackSlot(acked);
    checkOutput("addrAck", 32'(acked), 32'(modelMatched));
    checkOutput("busyAfterAddr", 32'(busy), 32'(modelMatched));
  endtask

  task automatic sendData(input logic [7:0] value);
    logic acked;
    logic expAck;
    expAck = modelMatched && (modelCount < NUM_BYTES);
    if (expAck) begin
      expRx.push_back('{data: value, idx: modelCount});
      modelCount++;
    end else if (modelMatched) begin
      modelOverflow = 1'b1;
    end
    sendBits(value, 8);
    ackSlot(acked);
    checkOutput("dataAck", 32'(acked), 32'(expAck));
  endtask

  task automatic endCheck();
    checkOutput("doneCount", 32'(doneSeen), 32'(expDone));
    checkOutput("byteCount", 32'(byteCount), 32'(modelCount));
    checkOutput("overflow", 32'(overflow), 32'(modelOverflow));
    checkOutput("busyAfterStop", 32'(busy), 32'd0);
    checkOutput("rxPending", 32'(expRx.size()), 32'd0);
  endtask

  task automatic runBasicWrite();
    int doneBefore;
    doneBefore = doneSeen;
    sendStart();
    sendAddr(8'h84);
    sendData(8'hA5);
    sendData(8'h3C);
    sendStop();
    endCheck();
    checkOutput("basicDonePulses", 32'(doneSeen - doneBefore), 32'd1);
    checkOutput("basicLastByte", 32'(lastRxByte), 32'h3C);
    checkOutput("basicLastIdx", 32'(lastRxIdx), 32'd1);
    checkOutput("basicByteCount", 32'(byteCount), 32'd2);
    checkOutput("basicOverflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    int doneBefore;
    rst       = 1'b1;
    sclPin    = 1'b1;
    sdaMaster = 1'b1;
    waitCycles(3);
    checkOutput("resetSdaPull", 32'(sdaPull), 32'd0);
    checkOutput("resetRxValid", 32'(rxValid), 32'd0);
    checkOutput("resetRxByte", 32'(rxByte), 32'd0);
    checkOutput("resetRxIndex", 32'(rxIndex), 32'd0);
    checkOutput("resetByteCount", 32'(byteCount), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetOverflow", 32'(overflow), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    rst = 1'b0;
    waitCycles(5);

    $display("[TB] basic two-byte write");
    runBasicWrite();

    $display("[TB] foreign address");
    sendStart();
    sendAddr(8'h86);
    sendData(8'h11);
    sendStop();
    endCheck();

    $display("[TB] read request");
    sendStart();
    sendAddr(8'h85);
    sendStop();
    endCheck();

    $display("[TB] overflow write");
    doneBefore = doneSeen;
    sendStart();
    sendAddr(8'h84);
    for (int i = 1; i <= 7; i++) sendData(8'(i));
    sendStop();
    endCheck();
    checkOutput("ovfByteCount", 32'(byteCount), 32'd6);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    checkOutput("ovfLastByte", 32'(lastRxByte), 32'h06);
    checkOutput("ovfLastIdx", 32'(lastRxIdx), 32'd5);
    checkOutput("ovfDonePulses", 32'(doneSeen - doneBefore), 32'd1);

    $display("[TB] repeated start");
    doneBefore = doneSeen;
    sendStart();
    sendAddr(8'h84);
    sendData(8'hAA);
    sendBits(8'h55, 4);
    sendStart();
    sendAddr(8'h84);
    sendData(8'h55);
    sendStop();
    endCheck();
    checkOutput("rsDonePulses", 32'(doneSeen - doneBefore), 32'd1);
    checkOutput("rsByteCount", 32'(byteCount), 32'd1);
    checkOutput("rsLastByte", 32'(lastRxByte), 32'h55);
    checkOutput("rsLastIdx", 32'(lastRxIdx), 32'd0);

    $display("[TB] reset during data ACK");
    sendStart();
    sendAddr(8'h84);
    expRx.push_back('{data: 8'hA5, idx: 0});
    modelCount++;
    sendBits(8'hA5, 8);
    checkOutput("pullBeforeReset", 32'(sdaPull), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("pullAsyncClear", 32'(sdaPull), 32'd0);
    waitCycles(2);
    rst           = 1'b0;
    modelMatched  = 1'b0;
    modelCount    = 0;
    modelOverflow = 1'b0;
    begin
      logic acked;
      ackSlot(acked);
      checkOutput("ackAfterReset", 32'(acked), 32'd0);
    end
    sendData(8'h5A);
    sendStop();
    endCheck();
    runBasicWrite();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
